splitter: RTL and testbench

//  Dataflow actor that inverts the block accumulator. It reads one DATA_W-bit sum token and

---
 rtl/mdc_actor_pkg.sv | 13 +
 rtl/splitter_if.sv | 26 ++
 rtl/splitter_share.sv | 16 +
 rtl/splitter.sv | 102 ++++++++++
 tb/tb_splitter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mdc_actor_pkg.sv
// Shared definitions for the block-distribution dataflow actors: state encoding
// and the default token width.
package mdc_actor_pkg;

  // LOAD/EMIT maps one-to-one onto the accumulator's ACC/RES phases.
  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } actor_state_e;

  localparam int TOKEN_W = 16;

endpackage

// File: rtl/splitter_if.sv
// FIFO-side handshake of the splitter: empty/rd on the input side, full/wr on the output side.
// The slave modport is the actor's view; the master modport is the FIFO/environment view.
interface splitter_if
  import mdc_actor_pkg::*;
#(
  parameter int DATA_W = TOKEN_W
) ();

  logic              in0_empty;
  logic [DATA_W-1:0] in0;
  logic              in0_rd;
  logic              out0_full;
  logic [DATA_W-1:0] out0;
  logic              out0_wr;

  modport master (
    output in0_empty, in0, out0_full,
    input  in0_rd, out0, out0_wr
  );

  modport slave (
    input  in0_empty, in0, out0_full,
    output in0_rd, out0, out0_wr
  );

endinterface

// File: rtl/splitter_share.sv
// Combinational share of a block distribution: quotient plus one while the
// output index is below the remainder.
module splitter_share #(
  parameter int DATA_W     = 16,
  parameter int LOG2_BLOCK = 3
) (
  input  logic [DATA_W-LOG2_BLOCK-1:0] i_quot,
  input  logic [LOG2_BLOCK-1:0]        i_rem,
  input  logic [LOG2_BLOCK-1:0]        i_count,
  output logic [DATA_W-1:0]            o_share
);

  // quot+1 never exceeds 2**(DATA_W-LOG2_BLOCK), so the sum always fits.
  assign o_share = DATA_W'(i_quot) + DATA_W'(i_count < i_rem);

endmodule

// File: rtl/splitter.sv
// Splitter actor: reads one sum token and emits 2**LOG2_BLOCK shares summing to it.
// Define SPLITTER_BACK2BACK_EN to overlap the last write of a block with the next read.
module splitter
  import mdc_actor_pkg::*;
#(
  parameter int DATA_W     = TOKEN_W,
  parameter int LOG2_BLOCK = 3
) (
  input  logic       clock,
  input  logic       reset,
  splitter_if.slave  bus
);

  localparam int                    QW   = DATA_W - LOG2_BLOCK;
  localparam logic [LOG2_BLOCK-1:0] LAST = '1;

  actor_state_e          r_state, w_state_nxt;
  logic [QW-1:0]         r_quot, w_quot_nxt;
  logic [LOG2_BLOCK-1:0] r_rem, w_rem_nxt;
  logic [LOG2_BLOCK-1:0] r_count, w_count_nxt;
  logic                  w_rd;
  logic                  w_wr;
  logic [DATA_W-1:0]     w_share;

  splitter_share #(
    .DATA_W    (DATA_W),
    .LOG2_BLOCK(LOG2_BLOCK)
  ) u_share (
    .i_quot (r_quot),
    .i_rem  (r_rem),
    .i_count(r_count),
    .o_share(w_share)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    w_state_nxt = r_state;
    w_quot_nxt  = r_quot;
    w_rem_nxt   = r_rem;
    w_count_nxt = r_count;
    w_rd        = 1'b0;
    w_wr        = 1'b0;

    case (r_state)
      LOAD: begin
        w_rd = !bus.in0_empty;
        if (w_rd) begin
          w_quot_nxt  = bus.in0[DATA_W-1:LOG2_BLOCK];
          w_rem_nxt   = bus.in0[LOG2_BLOCK-1:0];
          w_count_nxt = '0;
          w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        w_wr = !bus.out0_full;
        if (w_wr) begin
          if (r_count == LAST) begin
            w_count_nxt = '0;
            w_state_nxt = LOAD;
`ifdef SPLITTER_BACK2BACK_EN
            if (!bus.in0_empty) begin
              w_rd        = 1'b1;
              w_quot_nxt  = bus.in0[DATA_W-1:LOG2_BLOCK];
              w_rem_nxt   = bus.in0[LOG2_BLOCK-1:0];
              w_state_nxt = EMIT;
            end
`endif
          end else begin
            w_count_nxt = r_count + LOG2_BLOCK'(1);
          end
        end
      end
      default: w_state_nxt = LOAD;
    endcase

    // Strobes are silenced for as long as reset is held, not just at its edge.
    if (!reset) begin
      w_rd = 1'b0;
      w_wr = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= LOAD;
      r_quot  <= '0;
      r_rem   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_quot  <= w_quot_nxt;
      r_rem   <= w_rem_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign bus.in0_rd  = w_rd;
  assign bus.out0_wr = w_wr;
  assign bus.out0    = w_wr ? w_share : '0;

endmodule

// File: tb/tb_splitter.sv
// Self-checking bench for splitter: table-driven blocks plus stall, reset and
// back-to-back sequences, with a scoreboard of expected shares.
module tb_splitter;
  import mdc_actor_pkg::*;

  localparam int DW = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  splitter_if #(.DATA_W(DW)) bus ();

  splitter #(.DATA_W(DW), .LOG2_BLOCK(3)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] in0;
    logic [15:0] exp [8];
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] src_q [$];
  logic [15:0] exp_q [$];
  bit          pop_pending = 1'b0;
  int          cyc = 0;
  int          n_wr = 0;
  int          n_overlap = 0;
  int          first_rd_cyc = -1;
  int          last_wr_cyc = 0;
  logic [15:0] blk_sum = '0;
  logic [15:0] mon_exp;

  function automatic logic [15:0] share_model(input logic [15:0] tok, input int k);
    int q, r;
    q = int'(tok) / 8;
    r = int'(tok) % 8;
    return 16'(q + ((k < r) ? 1 : 0));
  endfunction

  task automatic drive_src();
    bus.in0_empty = (src_q.size() == 0);
    bus.in0       = (src_q.size() == 0) ? '0 : src_q[0];
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic push_model(input logic [15:0] tok);
    src_q.push_back(tok);
    for (int k = 0; k < 8; k++) exp_q.push_back(share_model(tok, k));
    drive_src();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int b = budget;
    while (exp_q.size() != 0 && b > 0) begin
      tick();
      b--;
    end
    check({name, " drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_writes(input string name, input int n, input int budget);
    int n0 = n_wr;
    int b  = budget;
    while ((n_wr - n0) < n && b > 0) begin
      tick();
      b--;
    end
    check({name, " writes seen"}, n_wr - n0, n);
  endtask

  // Input FIFO model: a read seen at the falling edge is consumed after the next rising edge.
  always @(posedge clock) begin
    #1;
    if (pop_pending) begin
      pop_pending = 1'b0;
      if (src_q.size() != 0) void'(src_q.pop_front());
    end
    drive_src();
  end

  // Output monitor: every write is scored against the expected-share queue.
  always @(negedge clock) begin
    cyc++;
    if (bus.out0_wr === 1'b1) begin
      n_wr++;
      last_wr_cyc = cyc;
      blk_sum     = blk_sum + bus.out0;
      if (bus.in0_rd === 1'b1) n_overlap++;
      if (exp_q.size() == 0) begin
        check("unexpected write", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("share", bus.out0, mon_exp);
      end
    end else begin
      check("out0 idle", bus.out0, 0);
    end
    if (bus.in0_rd === 1'b1) begin
      pop_pending = 1'b1;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int span;
    int ov0;

    vecs[0].in0 = 16'd19;
    vecs[0].exp = '{16'd3, 16'd3, 16'd3, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2};
    vecs[1].in0 = 16'd0;
    vecs[1].exp = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    vecs[2].in0 = 16'd8;
    vecs[2].exp = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
    vecs[3].in0 = 16'hFFFF;
    vecs[3].exp = '{16'h2000, 16'h2000, 16'h2000, 16'h2000,
                    16'h2000, 16'h2000, 16'h2000, 16'h1FFF};
    vecs[4].in0 = 16'd100;
    vecs[4].exp = '{16'd13, 16'd13, 16'd13, 16'd13, 16'd12, 16'd12, 16'd12, 16'd12};
    vecs[5].in0 = 16'd7;
    vecs[5].exp = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd0};

    // Reset held with a token waiting: strobes must stay low.
    bus.out0_full = 1'b0;
    src_q.push_back(16'd19);
    drive_src();
    tick();
    tick();
    check("reset in0_rd", bus.in0_rd, 0);
    check("reset out0_wr", bus.out0_wr, 0);
    check("reset out0", bus.out0, 0);
    check("reset state", dut.r_state, LOAD);
    check("reset count", dut.r_count, 0);
    src_q.delete();
    drive_src();
    reset = 1'b1;
    tick();
    check("idle in0_rd", bus.in0_rd, 0);

    foreach (vecs[i]) begin
      blk_sum = '0;
      src_q.push_back(vecs[i].in0);
      for (int k = 0; k < 8; k++) exp_q.push_back(vecs[i].exp[k]);
      drive_src();
      wait_drain($sformatf("vec%0d", i), 40);
      tick();
      check($sformatf("vec%0d rd waits", i), bus.in0_rd, 0);
      check($sformatf("vec%0d state LOAD", i), dut.r_state, LOAD);
      check($sformatf("vec%0d sum", i), blk_sum, vecs[i].in0);
    end

    // Output stall after the third write.
    push_model(16'd19);
    wait_writes("stall", 3, 20);
    bus.out0_full = 1'b1;
    #1;
    check("stall wr now", bus.out0_wr, 0);
    for (int s = 0; s < 5; s++) begin
      tick();
      check("stall wr", bus.out0_wr, 0);
      check("stall count", dut.r_count, 3);
    end
    bus.out0_full = 1'b0;
    wait_drain("stall resume", 20);
    tick();

    // Reset mid-block discards the rest of the block.
    push_model(16'd19);
    wait_writes("midreset", 3, 20);
    reset = 1'b0;
    #1;
    check("midreset in0_rd", bus.in0_rd, 0);
    check("midreset out0_wr", bus.out0_wr, 0);
    check("midreset out0", bus.out0, 0);
    check("midreset state", dut.r_state, LOAD);
    check("midreset count", dut.r_count, 0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    blk_sum = '0;
    push_model(16'd8);
    wait_drain("post reset", 40);
    check("post reset sum", blk_sum, 16'd8);
    tick();

    // Two queued tokens with an always-ready sink.
    first_rd_cyc = -1;
    ov0 = n_overlap;
    push_model(16'd19);
    push_model(16'd8);
    wait_drain("b2b", 60);
    span = last_wr_cyc - first_rd_cyc + 1;
`ifdef SPLITTER_BACK2BACK_EN
    check("b2b span", span, 17);
    check("b2b overlap", n_overlap - ov0, 1);
`else
    check("b2b span", span, 18);
    check("b2b overlap", n_overlap - ov0, 0);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
